// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//
// Shares one single-port, 32-bit synchronous instruction memory between the
// core fetch port (read-only) and the program-loader/debug port (read/write).
// At most one access is granted per cycle; each granted access gets exactly
// one response strobe in the following cycle.
//
// Optional feature macro: IMEM_ARB_RR_EN
//   defined   : round-robin between fetch and loader on a tie in ARB
//   undefined : fixed priority, fetch wins every tie
//
// Handshake: a request transfers in the cycle where *_req_valid && *_req_ready.
// *_req_ready is combinational from the valids and the arbiter state, never
// both high together. Responses (*_rsp_valid/*_rsp_data) have no backpressure
// and are valid for exactly one cycle, one cycle after the grant.
//
// Ports
//   clk, reset                 clock (rising edge), async active-high reset
//   f_req_valid/f_req_ready    fetch request / grant
//   f_addr                     fetch byte address
//   f_rsp_valid/f_rsp_data     fetch response strobe / instruction word
//   l_req_valid/l_req_ready    loader request / grant
//   l_we, l_lock               loader write enable, burst lock
//   l_addr, l_wdata            loader byte address, write data
//   l_rsp_valid/l_rsp_data     loader response strobe / read data (0 on writes)
//   locked                     arbiter state is LOCKED
//   mem_en, mem_we             array enable, write enable
//   mem_addr, mem_wdata        array word address, write data
//   mem_rdata                  array read data, valid one cycle after mem_en
// -----------------------------------------------------------------------------
module imem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              f_req_valid,
    output logic              f_req_ready,
    input  logic [31:0]       f_addr,
    output logic              f_rsp_valid,
    output logic [DATA_W-1:0] f_rsp_data,

    input  logic              l_req_valid,
    output logic              l_req_ready,
    input  logic              l_we,
    input  logic              l_lock,
    input  logic [31:0]       l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_rsp_valid,
    output logic [DATA_W-1:0] l_rsp_data,

    output logic              locked,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_FETCH  = 2'd1,
        OWN_LOADER = 2'd2
    } owner_e;

    state_e state_q, state_d;
    owner_e owner_q, owner_d;
    // Response data is forced to zero for out-of-range accesses and writes.
    logic   zero_q,  zero_d;

    logic f_gnt, l_gnt;
    logic f_oor, l_oor;

    // Byte-offset bits are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{f_addr[1:0], l_addr[1:0]};

    assign f_oor = |f_addr[31:ADDR_W+2];
    assign l_oor = |l_addr[31:ADDR_W+2];

`ifdef IMEM_ARB_RR_EN
    // 1 = loader was the last port granted in ARB; resets to loader so
    // fetch wins the first tie.
    logic last_l_q, last_l_d;
`endif

    // -------------------------------------------------------------------------
    // Arbitration, next state, memory drive
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        owner_d   = OWN_NONE;
        zero_d    = 1'b0;
        f_gnt     = 1'b0;
        l_gnt     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
`ifdef IMEM_ARB_RR_EN
        last_l_d  = last_l_q;
`endif

        // Gating on reset keeps every output at zero while reset is held,
        // even if requesters keep their valids up.
        if (!reset) begin
            case (state_q)
                ST_ARB: begin
                    if (f_req_valid && l_req_valid) begin
`ifdef IMEM_ARB_RR_EN
                        if (last_l_q) f_gnt = 1'b1;
                        else          l_gnt = 1'b1;
`else
                        f_gnt = 1'b1;
`endif
                    end else begin
                        f_gnt = f_req_valid;
                        l_gnt = l_req_valid;
                    end
                    // l_lock only matters when the loader actually wins.
                    if (l_gnt && l_lock) state_d = ST_LOCKED;
`ifdef IMEM_ARB_RR_EN
                    if (f_gnt || l_gnt) last_l_d = l_gnt;
`endif
                end
                ST_LOCKED: begin
                    l_gnt = l_req_valid;
                    // Lock release takes effect next cycle; a request in the
                    // releasing cycle is still served here.
                    if (!l_lock) state_d = ST_ARB;
                end
                default: state_d = ST_ARB;
            endcase
        end

        if (f_gnt) begin
            owner_d = OWN_FETCH;
            zero_d  = f_oor;
            if (!f_oor) begin
                mem_en   = 1'b1;
                mem_addr = f_addr[ADDR_W+1:2];
            end
        end else if (l_gnt) begin
            owner_d = OWN_LOADER;
            zero_d  = l_oor || l_we;
            if (!l_oor) begin
                mem_en   = 1'b1;
                mem_we   = l_we;
                mem_addr = l_addr[ADDR_W+1:2];
                if (l_we) mem_wdata = l_wdata;
            end
        end
    end

    assign f_req_ready = f_gnt;
    assign l_req_ready = l_gnt;
    assign locked      = (state_q == ST_LOCKED);

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ARB;
            owner_q <= OWN_NONE;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            zero_q  <= zero_d;
        end
    end

`ifdef IMEM_ARB_RR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_l_q <= 1'b1;
        else       last_l_q <= last_l_d;
    end
`endif

    // -------------------------------------------------------------------------
    // Response steering: mem_rdata belongs to whoever was granted last cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        f_rsp_valid = (owner_q == OWN_FETCH);
        l_rsp_valid = (owner_q == OWN_LOADER);
        f_rsp_data  = '0;
        l_rsp_data  = '0;
        if (f_rsp_valid && !zero_q) f_rsp_data = mem_rdata;
        if (l_rsp_valid && !zero_q) l_rsp_data = mem_rdata;
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_arbiter
//
// Drives imem_arbiter with directed and random traffic against a behavioural
// memory. A reference model decides, from the arbitration rules, which port
// should be granted each cycle and what its response must be; expected
// responses are queued per port and popped by the monitor when they appear.
// -----------------------------------------------------------------------------
module tb_imem_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef IMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic              f_req_valid = 1'b0;
    logic              f_req_ready;
    logic [31:0]       f_addr = '0;
    logic              f_rsp_valid;
    logic [DATA_W-1:0] f_rsp_data;
    logic              l_req_valid = 1'b0;
    logic              l_req_ready;
    logic              l_we = 1'b0;
    logic              l_lock = 1'b0;
    logic [31:0]       l_addr = '0;
    logic [DATA_W-1:0] l_wdata = '0;
    logic              l_rsp_valid;
    logic [DATA_W-1:0] l_rsp_data;
    logic              locked;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .f_req_valid (f_req_valid),
        .f_req_ready (f_req_ready),
        .f_addr      (f_addr),
        .f_rsp_valid (f_rsp_valid),
        .f_rsp_data  (f_rsp_data),
        .l_req_valid (l_req_valid),
        .l_req_ready (l_req_ready),
        .l_we        (l_we),
        .l_lock      (l_lock),
        .l_addr      (l_addr),
        .l_wdata     (l_wdata),
        .l_rsp_valid (l_rsp_valid),
        .l_rsp_data  (l_rsp_data),
        .locked      (locked),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // ---------------- behavioural memory array ----------------
    logic [DATA_W-1:0] ram     [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];

    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= ram[mem_addr];
            if (mem_we) ram[mem_addr] = mem_wdata;
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] f_exp_q[$];
    logic [DATA_W-1:0] l_exp_q[$];
    int f_gnt_cnt = 0;
    int l_gnt_cnt = 0;

    // reference model state
    bit m_locked      = 1'b0;
    bit m_last_loader = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return a < (32'd4 * DEPTH);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a / 4) % DEPTH;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        bit e_f, e_l, e_en, e_we;
        int e_addr;
        if (reset) begin
            check("rst_f_req_ready", {31'd0, f_req_ready}, 0);
            check("rst_l_req_ready", {31'd0, l_req_ready}, 0);
            check("rst_f_rsp_valid", {31'd0, f_rsp_valid}, 0);
            check("rst_l_rsp_valid", {31'd0, l_rsp_valid}, 0);
            check("rst_f_rsp_data", f_rsp_data, 0);
            check("rst_l_rsp_data", l_rsp_data, 0);
            check("rst_locked", {31'd0, locked}, 0);
            check("rst_mem_en", {31'd0, mem_en}, 0);
            check("rst_mem_we", {31'd0, mem_we}, 0);
            check("rst_mem_addr", {22'd0, mem_addr}, 0);
            check("rst_mem_wdata", mem_wdata, 0);
            f_exp_q.delete();
            l_exp_q.delete();
            m_locked      = 1'b0;
            m_last_loader = 1'b1;
        end else begin
            // responses due this cycle
            check("f_rsp_valid", {31'd0, f_rsp_valid}, (f_exp_q.size() != 0) ? 1 : 0);
            if (f_exp_q.size() != 0) begin
                logic [DATA_W-1:0] ef;
                ef = f_exp_q.pop_front();
                if (f_rsp_valid) check("f_rsp_data", f_rsp_data, ef);
            end
            check("l_rsp_valid", {31'd0, l_rsp_valid}, (l_exp_q.size() != 0) ? 1 : 0);
            if (l_exp_q.size() != 0) begin
                logic [DATA_W-1:0] el;
                el = l_exp_q.pop_front();
                if (l_rsp_valid) check("l_rsp_data", l_rsp_data, el);
            end

            // expected grants from the arbitration rules
            e_f = 1'b0;
            e_l = 1'b0;
            if (m_locked) begin
                e_l = l_req_valid;
            end else if (f_req_valid && l_req_valid) begin
                if (RR && !m_last_loader) e_l = 1'b1;
                else                      e_f = 1'b1;
            end else begin
                e_f = f_req_valid;
                e_l = l_req_valid;
            end
            check("f_req_ready", {31'd0, f_req_ready}, {31'd0, e_f});
            check("l_req_ready", {31'd0, l_req_ready}, {31'd0, e_l});
            check("locked", {31'd0, locked}, {31'd0, m_locked});

            e_en   = (e_f && in_range(f_addr)) || (e_l && in_range(l_addr));
            e_we   = e_l && l_we && in_range(l_addr);
            e_addr = e_f ? widx(f_addr) : widx(l_addr);
            check("mem_en", {31'd0, mem_en}, {31'd0, e_en});
            check("mem_we", {31'd0, mem_we}, {31'd0, e_we});
            if (e_en) check("mem_addr", {22'd0, mem_addr}, e_addr);
            if (e_we) check("mem_wdata", mem_wdata, l_wdata);

            if (f_req_valid && f_req_ready) f_gnt_cnt++;
            if (l_req_valid && l_req_ready) l_gnt_cnt++;

            // queue expected responses and update the reference memory
            if (e_f) f_exp_q.push_back(in_range(f_addr) ? ref_mem[widx(f_addr)] : '0);
            if (e_l) begin
                if (l_we) begin
                    l_exp_q.push_back('0);
                    if (in_range(l_addr)) ref_mem[widx(l_addr)] = l_wdata;
                end else begin
                    l_exp_q.push_back(in_range(l_addr) ? ref_mem[widx(l_addr)] : '0);
                end
            end

            // model state for next cycle
            if (m_locked) begin
                m_locked = l_lock;
            end else begin
                if (e_f || e_l) m_last_loader = e_l;
                if (e_l && l_lock) m_locked = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit fv, input logic [31:0] fa,
                         input bit lv, input bit we, input bit lk,
                         input logic [31:0] la, input logic [31:0] wd);
        f_req_valid = fv;
        f_addr      = fa;
        l_req_valid = lv;
        l_we        = we;
        l_lock      = lk;
        l_addr      = la;
        l_wdata     = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int f0, l0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] v;
            v = $urandom;
            ram[i]     = v;
            ref_mem[i] = v;
        end

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // loader write then fetch of the same word
        drive(0, 0, 1, 1, 0, 32'h0, 32'h00400293);
        drive(1, 32'h0, 0, 0, 0, 0, 0);
        idle(1);

        // both valid for four cycles
        f0 = f_gnt_cnt;
        l0 = l_gnt_cnt;
        for (int i = 0; i < 4; i++) drive(1, 32'h4, 1, 0, 0, 32'h8, 0);
        check("tie_fetch_grants", f_gnt_cnt - f0, RR ? 2 : 4);
        check("tie_loader_grants", l_gnt_cnt - l0, RR ? 2 : 0);
        idle(1);

        // locked burst of four writes while fetch waits
        drive(0, 0, 1, 1, 1, 32'h0, $urandom);
        drive(1, 32'h20, 1, 1, 1, 32'h4, $urandom);
        drive(1, 32'h20, 1, 1, 1, 32'h8, $urandom);
        f0 = f_gnt_cnt;
        drive(1, 32'h20, 1, 1, 0, 32'hC, $urandom);
        check("lock_fetch_blocked", f_gnt_cnt - f0, 0);
        drive(1, 32'h20, 0, 0, 0, 0, 0);
        check("fetch_after_unlock", f_gnt_cnt - f0, 1);
        idle(1);

        // out-of-range fetch and write
        drive(1, 32'h00001000, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 32'h00001000, 32'hDEADBEEF);
        idle(1);
        check("oor_write_array", ram[0], ref_mem[0]);
        drive(1, 32'h0, 0, 0, 0, 0, 0);

        // unaligned fetch selects word 1
        drive(1, 32'h6, 0, 0, 0, 0, 0);
        idle(1);

        // read-after-write from the loader, consecutive cycles
        drive(0, 0, 1, 1, 0, 32'h40, 32'h12345678);
        drive(0, 0, 1, 0, 0, 32'h40, 0);
        idle(1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] fa, la;
            fa = $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
            la = $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) fa = fa | (32'h1000 << $urandom_range(0, 19));
            if ($urandom_range(0, 15) == 0) la = la | (32'h1000 << $urandom_range(0, 19));
            drive($urandom_range(0, 1), fa, $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 3) == 0, la, $urandom);
        end
        idle(2);
        check("array_word0_final", ram[0], ref_mem[0]);
        check("array_word16_final", ram[16], ref_mem[16]);

        // reset in the cycle after a fetch grant
        drive(1, 32'h8, 0, 0, 0, 0, 0);
        reset = 1'b1;
        f_req_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1, 32'hC, 0, 0, 0, 0, 0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
